// File: rtl/lsu.sv
// lsu: RV32I memory-stage load/store unit.
// Runs byte/half/word loads and stores against a single-port, word-wide,
// synchronous data RAM. Sub-word stores use read-modify-write; accesses that
// cross a word boundary are split into a lo word and a hi word.
module lsu #(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              wr,
   input  logic [2:0]        funct3,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [31:0]       rdata,
   output logic [ADDR_W-3:0] ram_addr,
   output logic [31:0]       ram_in,
   output logic              ram_wen,
   input  logic [31:0]       ram_out
);

   typedef enum logic [2:0] {
      IDLE, RD_LO, CAP_LO, CAP_HI, WR_LO, WR_HI, RESP
   } state_t;

   state_t state, state_nx;

   // latched request
   logic              wr_q;
   logic [2:0]        f3_q;
   logic [1:0]        lane_q;
   logic [ADDR_W-3:0] wa_q;
   logic [31:0]       wdata_q;
   logic              ill_q;
   logic              span_q;
   logic [31:0]       lo_q;
   logic [31:0]       hi_q;

   // request decode (combinational on the live inputs)
   logic        accept;
   logic        legal_f3;
   logic [2:0]  req_size;
   logic [32:0] last_byte;
   logic        req_ill;
   logic        req_alsw;
   logic        req_span;

   // datapath
   logic [ADDR_W-3:0] wa_hi;
   logic [31:0] lo_w, hi_w;
   logic [63:0] pair;
   logic [63:0] pair_sh;
   logic [31:0] ld_raw;
   logic [31:0] ld_ext;
   logic [7:0]  base_be;
   logic [7:0]  be;
   logic [63:0] mask64;
   logic [63:0] data64;
   logic [63:0] merged;

   // Decode the incoming request: size, legality, alignment, word-span.
   always_comb begin
      legal_f3 = 1'b0;
      if (wr)
         legal_f3 = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      else
         legal_f3 = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b101);
      case (funct3[1:0])
         2'b00:   req_size = 3'd1;
         2'b01:   req_size = 3'd2;
         default: req_size = 3'd4;
      endcase
      // last byte touched must stay below 2^ADDR_W, including any high addr bits
      last_byte = {1'b0, addr} + {30'd0, req_size} - 33'd1;
      req_ill   = !legal_f3 || (last_byte[32:ADDR_W] != '0);
      req_alsw  = wr && (funct3 == 3'b010) && (addr[1:0] == 2'b00);
      req_span  = ({1'b0, addr[1:0]} + req_size) > 3'd4;
      accept    = req && ((state == IDLE) || (state == RESP));
   end

   // State register; reset aborts any access in flight.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state sequencing through read, capture and write phases.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE, RESP: begin
            state_nx = IDLE;
            if (accept) begin
               if (req_ill)       state_nx = RESP;
               else if (req_alsw) state_nx = WR_LO;
               else               state_nx = RD_LO;
            end
         end
         RD_LO:  state_nx = CAP_LO;
         CAP_LO: begin
            if (span_q)    state_nx = CAP_HI;
            else if (wr_q) state_nx = WR_LO;
            else           state_nx = RESP;
         end
         CAP_HI: state_nx = wr_q ? WR_LO : RESP;
         WR_LO:  state_nx = span_q ? WR_HI : RESP;
         WR_HI:  state_nx = RESP;
         default: state_nx = IDLE;
      endcase
   end

   // Word-pair view: the word arriving from RAM this cycle overrides the
   // stale capture register, so a load can finish on the capture edge.
   always_comb begin
      wa_hi   = wa_q + 1'b1;
      lo_w    = (state == CAP_LO) ? ram_out : lo_q;
      hi_w    = (state == CAP_HI) ? ram_out : hi_q;
      pair    = {hi_w, lo_w};
      pair_sh = pair >> {lane_q, 3'b000};
      ld_raw  = pair_sh[31:0];
      case (f3_q)
         3'b000:  ld_ext = {{24{ld_raw[7]}}, ld_raw[7:0]};
         3'b001:  ld_ext = {{16{ld_raw[15]}}, ld_raw[15:0]};
         3'b100:  ld_ext = {24'd0, ld_raw[7:0]};
         3'b101:  ld_ext = {16'd0, ld_raw[15:0]};
         default: ld_ext = ld_raw;
      endcase
   end

   // Store merge: only the addressed bytes take store data; the rest are
   // written back with the values just read.
   always_comb begin
      case (f3_q[1:0])
         2'b00:   base_be = 8'b0000_0001;
         2'b01:   base_be = 8'b0000_0011;
         default: base_be = 8'b0000_1111;
      endcase
      be     = base_be << lane_q;
      mask64 = '0;
      for (int i = 0; i < 8; i++)
         mask64[8*i +: 8] = {8{be[i]}};
      data64 = {32'd0, wdata_q} << {lane_q, 3'b000};
      merged = (pair & ~mask64) | (data64 & mask64);
   end

   // Latch the request at accept and capture RAM words as they arrive.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q    <= 1'b0;
         f3_q    <= 3'd0;
         lane_q  <= 2'd0;
         wa_q    <= '0;
         wdata_q <= 32'd0;
         ill_q   <= 1'b0;
         span_q  <= 1'b0;
         lo_q    <= 32'd0;
         hi_q    <= 32'd0;
      end else begin
         if (accept) begin
            wr_q    <= wr;
            f3_q    <= funct3;
            lane_q  <= addr[1:0];
            wa_q    <= addr[ADDR_W-1:2];
            wdata_q <= wdata;
            ill_q   <= req_ill;
            span_q  <= req_span;
         end
         if (state == CAP_LO) lo_q <= ram_out;
         if (state == CAP_HI) hi_q <= ram_out;
      end
   end

   // Load result register: written only on a load's entry to RESP.
   always_ff @(posedge clk) begin
      if (rst)
         rdata <= 32'd0;
      else if (!wr_q && (((state == CAP_LO) && !span_q) || (state == CAP_HI)))
         rdata <= ld_ext;
   end

   // RAM port and handshake outputs, decoded from state.
   always_comb begin
      busy     = !((state == IDLE) || (state == RESP));
      done     = (state == RESP);
      err      = (state == RESP) && ill_q;
      ram_addr = (((state == CAP_LO) && span_q) || (state == WR_HI)) ? wa_hi : wa_q;
      ram_wen  = ((state == WR_LO) || (state == WR_HI)) && !rst;
      ram_in   = 32'd0;
      if (state == WR_LO) ram_in = merged[31:0];
      if (state == WR_HI) ram_in = merged[63:32];
   end

endmodule
